// File: rtl/pixel_collector.sv
// pixel_collector: gathers one iteration result per engine into a batch buffer,
// pulses fin_flag to advance the coordinate distributor, then streams the batch
// out in raster order with start/end-of-frame markers.
// Ports: clk/reset_n (async active-low, deassert synchronised); engine_done/engine_iter
// from the engines; fin_flag to the distributor; out_valid/out_ready/out_data/out_sop/out_eop stream.
// Latency: 1 CAPTURE cycle after all engines are done, then 1 pixel per accepted cycle.
// Backpressure: out_ready low stalls the drain; data/sop/eop hold stable while stalled.
module pixel_collector #(
  parameter int PIXEL_DATA_WIDTH = 32,
  parameter int ITER_WIDTH       = 16,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int NUM_ENGINES      = 30
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_ENGINES-1:0] engine_done,
  input  logic [ITER_WIDTH-1:0]  engine_iter [NUM_ENGINES],
  output logic                   fin_flag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ITER_WIDTH-1:0]  out_data,
  output logic                   out_sop,
  output logic                   out_eop
);

  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [PIXEL_DATA_WIDTH-1:0] PX_LAST  = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] PY_LAST  = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [IDX_W-1:0]            IDX_LAST = IDX_W'(NUM_ENGINES - 1);

  typedef enum logic [1:0] {WAIT, CAPTURE, DRAIN} state_t;

  // Reset release is retimed by one flop so the FSM leaves reset on a clean
  // edge; its first WAIT evaluation lands on the second rising edge.
  logic rst_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 1'b0;
    else          rst_sync_q <= 1'b1;
  end

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PIXEL_DATA_WIDTH-1:0] px_q, px_d, py_q, py_d;
  logic [ITER_WIDTH-1:0] buffer_q [NUM_ENGINES];
  logic [ITER_WIDTH-1:0] buffer_d [NUM_ENGINES];
  logic                  fin_q, fin_d;
  logic                  valid_q, valid_d;
  logic [ITER_WIDTH-1:0] data_q, data_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;

  // Raster position after the current pixel is accepted (compare-and-wrap).
  logic [PIXEL_DATA_WIDTH-1:0] px_adv, py_adv;
  logic [IDX_W-1:0]            idx_nxt;

  always_comb begin
    px_adv = px_q + 1'b1;
    py_adv = py_q;
    if (px_q == PX_LAST) begin
      px_adv = '0;
      py_adv = (py_q == PY_LAST) ? '0 : py_q + 1'b1;
    end
    idx_nxt = idx_q + 1'b1;
  end

  // Outputs are registered, so each branch computes what the outputs must
  // show in the state being entered.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    px_d     = px_q;
    py_d     = py_q;
    buffer_d = buffer_q;
    fin_d    = 1'b0;
    valid_d  = valid_q;
    data_d   = data_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    case (state_q)
      WAIT: begin
        if (&engine_done) begin
          state_d = CAPTURE;
          fin_d   = 1'b1;
        end
      end
      CAPTURE: begin
        // Engines still hold their results during the fin_flag cycle.
        buffer_d = engine_iter;
        idx_d    = '0;
        state_d  = DRAIN;
        valid_d  = 1'b1;
        data_d   = engine_iter[0];
        sop_d    = (px_q == '0) && (py_q == '0);
        eop_d    = (px_q == PX_LAST) && (py_q == PY_LAST);
      end
      DRAIN: begin
        if (out_ready) begin
          px_d = px_adv;
          py_d = py_adv;
          if (idx_q == IDX_LAST) begin
            state_d = WAIT;
            valid_d = 1'b0;
            data_d  = '0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
          end else begin
            idx_d  = idx_nxt;
            data_d = buffer_q[idx_nxt];
            sop_d  = (px_adv == '0) && (py_adv == '0);
            eop_d  = (px_adv == PX_LAST) && (py_adv == PY_LAST);
          end
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q  <= WAIT;
      idx_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      buffer_q <= '{default: '0};
      fin_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      px_q     <= px_d;
      py_q     <= py_d;
      buffer_q <= buffer_d;
      fin_q    <= fin_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  assign fin_flag  = fin_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;

endmodule

// File: tb/tb_pixel_collector.sv
// tb_pixel_collector: directed batches against a pixel scoreboard for pixel_collector
// configured as an 8x4 raster with 4 engines and 8-bit iteration counts.
module tb_pixel_collector;

  localparam int PW = 32;
  localparam int IW = 8;
  localparam int SW = 8;
  localparam int SH = 4;
  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NE-1:0] engine_done = '0;
  logic [IW-1:0] engine_iter [NE];
  logic          fin_flag;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [IW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;

  pixel_collector #(
    .PIXEL_DATA_WIDTH(PW),
    .ITER_WIDTH      (IW),
    .SCREEN_WIDTH    (SW),
    .SCREEN_HEIGHT   (SH),
    .NUM_ENGINES     (NE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .engine_done(engine_done),
    .engine_iter(engine_iter),
    .fin_flag   (fin_flag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] data;
    logic          sop;
    logic          eop;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   eop_cnt = 0;
  int   bx = 0;
  int   by = 0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Expected pixels of one batch: iteration base+i at the model's raster position.
  task automatic push_exp(input int base);
    exp_t e;
    for (int i = 0; i < NE; i++) begin
      e.data = IW'(base + i);
      e.sop  = (bx == 0) && (by == 0);
      e.eop  = (bx == SW - 1) && (by == SH - 1);
      exp_q.push_back(e);
      if (bx == SW - 1) begin
        bx = 0;
        by = (by == SH - 1) ? 0 : by + 1;
      end else begin
        bx = bx + 1;
      end
    end
  endtask

  task automatic set_batch(input int base);
    for (int i = 0; i < NE; i++) engine_iter[i] = IW'(base + i);
    push_exp(base);
  endtask

  task automatic wait_fin(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (fin_flag) ok = 1'b1;
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    chk(name, ok, 1'b1);
  endtask

  // Ready driver: mode 0 always ready, mode 1 repeats 1,0,0.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      cyc++;
    end
  end

  // Monitor: pops on every accepted pixel; while stalled, the presented pixel
  // must already equal the next expected one.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel data=%0d sop=%0b eop=%0b", out_data, out_sop, out_eop);
      end else if (out_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        acc_cnt++;
        if (out_eop) eop_cnt++;
        checks++;
        if ({out_data, out_sop, out_eop} !== {e.data, e.sop, e.eop}) begin
          errors++;
          $display("FAIL pixel got data=%0d sop=%0b eop=%0b want data=%0d sop=%0b eop=%0b",
                   out_data, out_sop, out_eop, e.data, e.sop, e.eop);
        end
      end else begin
        checks++;
        if ({out_data, out_sop, out_eop} !== {exp_q[0].data, exp_q[0].sop, exp_q[0].eop}) begin
          errors++;
          $display("FAIL stall_hold got data=%0d sop=%0b eop=%0b want data=%0d sop=%0b eop=%0b",
                   out_data, out_sop, out_eop, exp_q[0].data, exp_q[0].sop, exp_q[0].eop);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc;
    int eop0;
    int nfin;
    int vcnt;
    bit ok;
    for (int i = 0; i < NE; i++) engine_iter[i] = '0;

    // Reset state
    #3;
    chk("rst_fin", fin_flag, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Scenario 1: full batch, ready held high, 4 consecutive pixels.
    set_batch(1);
    engine_done = 4'b1111;
    wait_fin("s1_fin");
    engine_done = 4'b0000;
    for (int i = 0; i < NE; i++) begin
      @(negedge clk);
      chk("s1_consecutive_valid", out_valid, 1);
    end
    @(negedge clk);
    chk("s1_valid_low_after", out_valid, 0);
    wait_drain("s1_drain");

    // Scenario 2: partial done must not capture.
    set_batch(10);
    engine_done = 4'b0111;
    repeat (10) begin
      @(negedge clk);
      chk("s2_no_fin", fin_flag, 0);
      chk("s2_no_valid", out_valid, 0);
    end
    engine_done = 4'b1111;
    @(negedge clk);
    chk("s2_capture_next_edge", fin_flag, 1);
    engine_done = 4'b0000;
    wait_drain("s2_drain");

    // Scenario 3: stalled drain with ready 1,0,0,...
    base_acc = acc_cnt;
    rdy_mode = 1;
    set_batch(20);
    engine_done = 4'b1111;
    wait_fin("s3_fin");
    engine_done = 4'b0000;
    wait_drain("s3_drain");
    repeat (4) @(negedge clk);
    chk("s3_accepts", acc_cnt - base_acc, NE);
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    // Scenario 5: reset after two of four pixels accepted.
    base_acc = acc_cnt;
    set_batch(30);
    engine_done = 4'b1111;
    wait_fin("s5_fin");
    engine_done = 4'b0000;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      if (acc_cnt >= base_acc + 2) ok = 1'b1;
    end
    chk("s5_two_accepts", ok, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("s5_rst_fin", fin_flag, 0);
    chk("s5_rst_valid", out_valid, 0);
    chk("s5_rst_data", out_data, 0);
    chk("s5_rst_sop", out_sop, 0);
    chk("s5_rst_eop", out_eop, 0);
    exp_q.delete();
    bx = 0;
    by = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scenario 4: 8 batches from (0,0) cover the full 8x4 frame.
    eop0 = eop_cnt;
    for (int b = 0; b < 8; b++) begin
      set_batch(40 + b * NE);
      engine_done = 4'b1111;
      wait_fin("s4_fin");
      engine_done = 4'b0000;
      wait_drain("s4_drain");
    end
    repeat (2) @(negedge clk);
    chk("s4_eop_once", eop_cnt - eop0, 1);

    // Scenario 6: done held high; one capture per batch, none during drain.
    for (int i = 0; i < NE; i++) engine_iter[i] = IW'(100 + i);
    engine_done = 4'b1111;
    nfin = 0;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("s6_no_fin_in_drain", fin_flag & out_valid, 0);
      if (fin_flag) begin
        if (nfin > 0) chk("s6_pixels_per_fin", vcnt, NE);
        vcnt = 0;
        nfin++;
        push_exp(100);
      end
      if (out_valid && out_ready) vcnt++;
    end
    engine_done = 4'b0000;
    chk("s6_min_batches", nfin >= 5, 1);
    wait_drain("s6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
